// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-port front end that shares a single 32-bit ALU.
//               Requests are granted round-robin (or fixed priority when
//               ALU_ARB_FIXED_PRIO_EN is defined). One transaction is in
//               flight at a time: IDLE -> EXEC -> WAIT -> IDLE.
//               Each port owns a response register set that holds its last
//               result until consumed.
// Config      : `define ALU_ARB_FIXED_PRIO_EN -> port 0 always wins contention
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter (
   input  logic        clk,
   input  logic        reset,
   // requester 0
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_op,
   // requester 1
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_op,
   // response 0
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_carryout,
   output logic        rsp0_zero,
   output logic        rsp0_overflow,
   // response 1
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_carryout,
   output logic        rsp1_zero,
   output logic        rsp1_overflow,
   // status
   output logic        busy
);

   localparam logic [2:0] c_op_add = 3'd0;
   localparam logic [2:0] c_op_sub = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic        id_q, id_d;

   logic        rsp0_valid_q, rsp0_valid_d;
   logic [31:0] rsp0_result_q, rsp0_result_d;
   logic        rsp0_carry_q, rsp0_carry_d;
   logic        rsp0_zero_q, rsp0_zero_d;
   logic        rsp0_ovf_q, rsp0_ovf_d;

   logic        rsp1_valid_q, rsp1_valid_d;
   logic [31:0] rsp1_result_q, rsp1_result_d;
   logic        rsp1_carry_q, rsp1_carry_d;
   logic        rsp1_zero_q, rsp1_zero_d;
   logic        rsp1_ovf_q, rsp1_ovf_d;

   logic        w_gnt_id;
   logic        w_hs;
   logic [31:0] w_alu_result;
   logic        w_alu_carry;
   logic        w_alu_ovf;
   logic        w_alu_zero;
   logic        w_arith;

   // Shared ALU always works on the registered operands
   ALU32bit u_alu (
      .a        (a_q),
      .b        (b_q),
      .op       (op_q),
      .result   (w_alu_result),
      .carryout (w_alu_carry),
      .overflow (w_alu_ovf),
      .zero     (w_alu_zero)
   );

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: port 1 only wins when port 0 is idle
   always_comb begin
      w_gnt_id = 1'b0;
      if (!req0_valid && req1_valid) begin
         w_gnt_id = 1'b1;
      end
   end
`else
   logic last_q, last_d;

   // Round-robin: on contention the port not served last wins
   always_comb begin
      w_gnt_id = 1'b0;
      if (req0_valid && req1_valid) begin
         w_gnt_id = ~last_q;
      end else if (req1_valid) begin
         w_gnt_id = 1'b1;
      end
      last_d = w_hs ? w_gnt_id : last_q;
   end

   // Pointer register; reset value makes port 0 win the first contention
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Ready only for the granted port in IDLE, and never while in reset
   always_comb begin
      req0_ready = (state_q == ST_IDLE) && !reset && req0_valid && !w_gnt_id;
      req1_ready = (state_q == ST_IDLE) && !reset && req1_valid && w_gnt_id;
      w_hs       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   end

   // Next-state, operand capture and response capture
   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      op_d          = op_q;
      id_d          = id_q;
      rsp0_valid_d  = rsp0_valid_q;
      rsp0_result_d = rsp0_result_q;
      rsp0_carry_d  = rsp0_carry_q;
      rsp0_zero_d   = rsp0_zero_q;
      rsp0_ovf_d    = rsp0_ovf_q;
      rsp1_valid_d  = rsp1_valid_q;
      rsp1_result_d = rsp1_result_q;
      rsp1_carry_d  = rsp1_carry_q;
      rsp1_zero_d   = rsp1_zero_q;
      rsp1_ovf_d    = rsp1_ovf_q;
      // Only ADD/SUB expose adder carry and overflow
      w_arith       = (op_q == c_op_add) || (op_q == c_op_sub);

      case (state_q)
         ST_IDLE: begin
            if (w_hs) begin
               a_d     = w_gnt_id ? req1_a  : req0_a;
               b_d     = w_gnt_id ? req1_b  : req0_b;
               op_d    = w_gnt_id ? req1_op : req0_op;
               id_d    = w_gnt_id;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!id_q) begin
               rsp0_valid_d  = 1'b1;
               rsp0_result_d = w_alu_result;
               rsp0_carry_d  = w_alu_carry & w_arith;
               rsp0_zero_d   = w_alu_zero;
               rsp0_ovf_d    = w_alu_ovf & w_arith;
            end else begin
               rsp1_valid_d  = 1'b1;
               rsp1_result_d = w_alu_result;
               rsp1_carry_d  = w_alu_carry & w_arith;
               rsp1_zero_d   = w_alu_zero;
               rsp1_ovf_d    = w_alu_ovf & w_arith;
            end
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!id_q && rsp0_ready) begin
               rsp0_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end else if (id_q && rsp1_ready) begin
               rsp1_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operand and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         a_q           <= 32'h0;
         b_q           <= 32'h0;
         op_q          <= 3'd0;
         id_q          <= 1'b0;
         rsp0_valid_q  <= 1'b0;
         rsp0_result_q <= 32'h0;
         rsp0_carry_q  <= 1'b0;
         rsp0_zero_q   <= 1'b0;
         rsp0_ovf_q    <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp1_result_q <= 32'h0;
         rsp1_carry_q  <= 1'b0;
         rsp1_zero_q   <= 1'b0;
         rsp1_ovf_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         op_q          <= op_d;
         id_q          <= id_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp0_carry_q  <= rsp0_carry_d;
         rsp0_zero_q   <= rsp0_zero_d;
         rsp0_ovf_q    <= rsp0_ovf_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp1_result_q <= rsp1_result_d;
         rsp1_carry_q  <= rsp1_carry_d;
         rsp1_zero_q   <= rsp1_zero_d;
         rsp1_ovf_q    <= rsp1_ovf_d;
      end
   end

   // Output mapping
   always_comb begin
      busy          = (state_q != ST_IDLE);
      rsp0_valid    = rsp0_valid_q;
      rsp0_result   = rsp0_result_q;
      rsp0_carryout = rsp0_carry_q;
      rsp0_zero     = rsp0_zero_q;
      rsp0_overflow = rsp0_ovf_q;
      rsp1_valid    = rsp1_valid_q;
      rsp1_result   = rsp1_result_q;
      rsp1_carryout = rsp1_carry_q;
      rsp1_zero     = rsp1_zero_q;
      rsp1_overflow = rsp1_ovf_q;
   end

endmodule

// ============================================================================
// Module      : ALU32bit
// Description : Combinational 32-bit ALU. SUB and SLT share the adder with
//               b inverted and carry-in set; carry/overflow are raw adder flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ALU32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   output logic [31:0] result,
   output logic        carryout,
   output logic        overflow,
   output logic        zero
);

   localparam logic [2:0] c_op_add  = 3'd0;
   localparam logic [2:0] c_op_sub  = 3'd1;
   localparam logic [2:0] c_op_xor  = 3'd2;
   localparam logic [2:0] c_op_slt  = 3'd3;
   localparam logic [2:0] c_op_and  = 3'd4;
   localparam logic [2:0] c_op_nand = 3'd5;
   localparam logic [2:0] c_op_nor  = 3'd6;
   localparam logic [2:0] c_op_or   = 3'd7;

   logic        w_sub;
   logic [31:0] w_b_eff;
   logic [32:0] w_sum;

   // Adder shared by ADD/SUB/SLT, then result mux
   always_comb begin
      w_sub    = (op == c_op_sub) || (op == c_op_slt);
      w_b_eff  = w_sub ? ~b : b;
      w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {32'h0, w_sub};
      carryout = w_sum[32];
      overflow = (a[31] == w_b_eff[31]) && (w_sum[31] != a[31]);
      case (op)
         c_op_add:  result = w_sum[31:0];
         c_op_sub:  result = w_sum[31:0];
         c_op_xor:  result = a ^ b;
         c_op_slt:  result = {31'h0, w_sum[31] ^ overflow};
         c_op_and:  result = a & b;
         c_op_nand: result = ~(a & b);
         c_op_nor:  result = ~(a | b);
         c_op_or:   result = a | b;
         default:   result = 32'h0;
      endcase
      zero = (result == 32'h0);
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter: table of single-port
//               operations plus directed contention, stall and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

   logic        clk;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_carryout, rsp0_zero, rsp0_overflow;
   logic        rsp1_carryout, rsp1_zero, rsp1_overflow;
   logic        busy;

   int checks = 0;
   int errors = 0;

   alu_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_a        (req0_a),
      .req0_b        (req0_b),
      .req0_op       (req0_op),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_a        (req1_a),
      .req1_b        (req1_b),
      .req1_op       (req1_op),
      .rsp0_valid    (rsp0_valid),
      .rsp0_ready    (rsp0_ready),
      .rsp0_result   (rsp0_result),
      .rsp0_carryout (rsp0_carryout),
      .rsp0_zero     (rsp0_zero),
      .rsp0_overflow (rsp0_overflow),
      .rsp1_valid    (rsp1_valid),
      .rsp1_ready    (rsp1_ready),
      .rsp1_result   (rsp1_result),
      .rsp1_carryout (rsp1_carryout),
      .rsp1_zero     (rsp1_zero),
      .rsp1_overflow (rsp1_overflow),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          port;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] res;
      logic        c;
      logic        z;
      logic        v;
      logic        chk_c;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int port, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      if (port == 0) begin
         req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
      end
   endtask

   task automatic clr_req(input int port);
      if (port == 0) req0_valid = 1'b0;
      else           req1_valid = 1'b0;
   endtask

   function automatic logic rdy(input int p);
      return (p == 0) ? req0_ready : req1_ready;
   endfunction

   function automatic logic rv(input int p);
      return (p == 0) ? rsp0_valid : rsp1_valid;
   endfunction

   function automatic logic [31:0] rres(input int p);
      return (p == 0) ? rsp0_result : rsp1_result;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   // One complete transaction on a single port with latency and value checks
   task automatic txn(input int port, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] er, input logic ec, input logic ez, input logic ev,
                      input logic chk_c, input logic [31:0] other_res);
      int n;
      int o;
      o = 1 - port;
      set_req(port, a, b, op);
      #1;
      n = 0;
      while (!rdy(port) && n < 8) begin
         tick();
         n++;
      end
      chk("hs_ready", rdy(port), 1);
      tick();
      clr_req(port);
      chk("exec_busy", busy, 1);
      chk("exec_rsp_valid", rv(port), 0);
      chk("exec_ready", rdy(port), 0);
      tick();
      chk("rsp_valid", rv(port), 1);
      chk("rsp_result", rres(port), er);
      chk("rsp_zero", (port == 0) ? rsp0_zero : rsp1_zero, ez);
      chk("rsp_ovf", (port == 0) ? rsp0_overflow : rsp1_overflow, ev);
      if (chk_c) chk("rsp_carry", (port == 0) ? rsp0_carryout : rsp1_carryout, ec);
      chk("other_valid", rv(o), 0);
      chk("other_result_kept", rres(o), other_res);
      if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      chk("rsp_cleared", rv(port), 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      logic [31:0] last_res [2];
      int g_port [8];
      int g_cyc [8];
      int g_cnt;

      // port, a, b, op, result, carry, zero, overflow, check-carry
      tbl[0]  = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{0, 32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{1, 32'h80000000, 32'h00000001, 3'd1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1, 32'h00000003, 32'h00000003, 3'd1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{0, 32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1, 32'h81234567, 32'hFFFFFFFF, 3'd3, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{0, 32'h00000005, 32'hFFFFFFFF, 3'd3, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1, 32'hFFFF0000, 32'h0F0F0F0F, 3'd4, 32'h0F0F0000, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1, 32'h00000000, 32'h00000000, 3'd6, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{0, 32'h80000000, 32'h80000000, 3'd7, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{0, 32'h12340000, 32'h00005678, 3'd7, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1, 32'h80000000, 32'h80000000, 3'd0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1};

      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 32'h0; req0_b = 32'h0; req0_op = 3'd0;
      req1_a = 32'h0; req1_b = 32'h0; req1_op = 3'd0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick();
      tick();

      // Reset state, with requests presented while reset is held
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp0_result", rsp0_result, 0);
      chk("rst_rsp1_result", rsp1_result, 0);
      chk("rst_rsp0_flags", {rsp0_carryout, rsp0_zero, rsp0_overflow}, 0);
      chk("rst_rsp1_flags", {rsp1_carryout, rsp1_zero, rsp1_overflow}, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b0;
      tick();

      // Table of single-port operations
      last_res[0] = 32'h0;
      last_res[1] = 32'h0;
      for (int i = 0; i < 14; i++) begin
         txn(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].v,
             tbl[i].chk_c, last_res[1 - tbl[i].port]);
         last_res[tbl[i].port] = tbl[i].res;
      end

      // Contention right after reset: port 0 first, then port 1
      do_reset();
      set_req(0, 32'h12345678, 32'h12345678, 3'd1);
      set_req(1, 32'h81234567, 32'hFFFFFFFF, 3'd3);
      #1;
      chk("c35_ready0", req0_ready, 1);
      chk("c35_ready1", req1_ready, 0);
      tick();
      clr_req(0);
      chk("c35_exec_ready1", req1_ready, 0);
      tick();
      chk("c35_rsp0_valid", rsp0_valid, 1);
      chk("c35_rsp0_result", rsp0_result, 32'h0);
      chk("c35_rsp0_zero", rsp0_zero, 1);
      chk("c35_rsp1_valid", rsp1_valid, 0);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      chk("c35_rsp0_cleared", rsp0_valid, 0);
      chk("c35_ready1_idle", req1_ready, 1);
      tick();
      clr_req(1);
      tick();
      chk("c35_rsp1_valid", rsp1_valid, 1);
      chk("c35_rsp1_result", rsp1_result, 32'h1);
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
      chk("c35_rsp1_cleared", rsp1_valid, 0);

      // Continuous contention: grant order and spacing
      do_reset();
      set_req(0, 32'h1, 32'h1, 3'd0);
      set_req(1, 32'h2, 32'h2, 3'd0);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      g_cnt = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (g_cnt < 8 && req0_ready && req0_valid) begin
            g_port[g_cnt] = 0; g_cyc[g_cnt] = cyc; g_cnt++;
         end
         if (g_cnt < 8 && req1_ready && req1_valid) begin
            g_port[g_cnt] = 1; g_cyc[g_cnt] = cyc; g_cnt++;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      chk("rr_count", g_cnt, 4);
      for (int k = 0; k < 4 && k < g_cnt; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         chk("grant_port", g_port[k], 0);
`else
         chk("grant_port", g_port[k], k % 2);
`endif
         chk("grant_cycle", g_cyc[k], 3 * k);
      end
      tick();
      tick();

      // Stalled response: held stable while rsp0_ready stays low
      do_reset();
      set_req(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0);
      set_req(1, 32'h5, 32'h6, 3'd2);
      #1;
      chk("c37_ready0", req0_ready, 1);
      tick();
      clr_req(0);
      tick();
      for (int s = 0; s < 5; s++) begin
         chk("c37_valid", rsp0_valid, 1);
         chk("c37_result", rsp0_result, 32'hFFFFFFFE);
         chk("c37_carry", rsp0_carryout, 1);
         chk("c37_readys", {req0_ready, req1_ready}, 0);
         chk("c37_busy", busy, 1);
         tick();
      end
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      chk("c37_released", rsp0_valid, 0);
      chk("c37_idle", busy, 0);

      // Reset while in EXEC drops the transaction
      set_req(0, 32'h1, 32'h2, 3'd0);
      #1;
      tick();
      clr_req(0);
      chk("c38_in_exec", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("c38_rsp0_valid", rsp0_valid, 0);
      chk("c38_rsp1_valid", rsp1_valid, 0);
      chk("c38_busy", busy, 0);
      tick();
      chk("c38_no_late_rsp", rsp0_valid, 0);
      chk("c38_still_idle", busy, 0);
      txn(1, 32'h0, 32'h0, 3'd6, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits and the op code width at 3 bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Ports req0_valid and req1_valid, input, 1 bit each: requester i presents an operation.
REQ-005 Ports req0_ready and req1_ready, output, 1 bit each: requester i's operation is accepted this cycle.
REQ-006 Ports req0_a, req0_b, req1_a and req1_b, input, 32 bits each: operands.
REQ-007 Ports req0_op and req1_op, input, 3 bits each: op code, where 0=ADD, 1=SUB, 2=XOR, 3=SLT, 4=AND, 5=NAND, 6=NOR, 7=OR.
REQ-008 Ports rsp0_valid and rsp1_valid, output, 1 bit each: a result is held for requester i.
REQ-009 Ports rsp0_ready and rsp1_ready, input, 1 bit each: requester i consumes its result.
REQ-010 Ports rsp0_result and rsp1_result, output, 32 bits each: the result.
REQ-011 Ports rsp0_carryout, rsp0_zero, rsp0_overflow, rsp1_carryout, rsp1_zero and rsp1_overflow, output, 1 bit each: the flags.
REQ-012 Port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-013 The block SHALL share one ALU32bit instance between the two requesters, with one transaction in flight at a time.
REQ-014 The FSM SHALL have three states: IDLE, EXEC and WAIT.
REQ-015 In IDLE, reqi_ready SHALL be asserted only for the granted port i; a handshake is reqi_valid && reqi_ready.
REQ-016 Grant: if only one port is valid, that port is granted; if both are valid, the port not granted last is granted (round-robin); the pointer updates only on a handshake.
REQ-017 On a handshake, a, b, op and the port id SHALL be registered and the FSM SHALL go IDLE->EXEC.
REQ-018 In EXEC, the ALU SHALL operate on the registered operands; at the end of EXEC, the result and flags SHALL be captured into port i's response registers, rspi_valid set to 1, and the FSM SHALL go EXEC->WAIT.
REQ-019 Latency: a handshake at the cycle-T edge SHALL make rspi_valid high from T+2.
REQ-020 In WAIT, the response outputs SHALL be stable until rspi_ready=1; then rspi_valid clears on the next edge and the FSM SHALL go WAIT->IDLE.
REQ-021 Maximum throughput is one operation per 3 cycles.
REQ-022 Both reqi_ready outputs SHALL be 0 in EXEC and in WAIT.
REQ-023 Flags: ADD and SUB report carryout and overflow as the ALU computes them; all other ops force carryout=0 and overflow=0.
REQ-024 For every op, zero SHALL be 1 exactly when result==32'h0.
REQ-025 SLT SHALL yield 32'h1 when signed a<b, else 32'h0.
REQ-026 Arithmetic wraps modulo 2^32.
REQ-027 The non-granted port's rspi outputs SHALL keep their previous values, with rspi_valid=0.

Reset
REQ-028 With reset=1 at an edge, the FSM SHALL go to IDLE from any state, and any in-flight transaction SHALL be discarded without a response.
REQ-029 Reset SHALL clear all rsp outputs (valid, result and flags) to 0, and clear busy to 0.
REQ-030 Reset SHALL set the round-robin pointer so that port 0 wins the first contention.
REQ-031 While reset=1, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-032 The macro ALU_ARB_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority: port 0 always wins when both are valid, and the pointer logic is omitted.
REQ-033 When ALU_ARB_FIXED_PRIO_EN is undefined, the round-robin behaviour of REQ-016 applies.

Verification
REQ-034 Port 0 alone, ADD 7FFFFFFF+7FFFFFFF -> rsp0 at T+2 with result FFFFFFFE, overflow=1, carryout=0, zero=0.
REQ-035 After reset, both valid: port 0 SUB 12345678-12345678 and port 1 SLT 81234567,FFFFFFFF -> port 0 served first (result 0, zero=1), then port 1 (result 00000001).
REQ-036 Both ports continuously valid with rsp_ready=1 -> grant order 0,1,0,1, one handshake every 3 cycles.
REQ-037 Port 0 ADD FFFFFFFF+FFFFFFFF with rsp0_ready held 0 for 5 cycles -> result FFFFFFFE and carryout=1 held stable, both req ready=0, busy=1 throughout.
REQ-038 Reset asserted during EXEC -> the next cycle has no rsp valid and busy=0; then port 1 alone, NOR 0,0 -> result FFFFFFFF, zero=0.
REQ-039 With ALU_ARB_FIXED_PRIO_EN defined and both ports continuously valid -> port 0 is granted every time and port 1 never.
